// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery sequencer: tracks live spectags and their age order,
// kills younger work on a mispredict, holds dispatch for rename restore, then redirects fetch.
module branch_recovery_ctrl #(
   parameter int NTAGS          = 4,
   parameter int RESTORE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              Flush,
   input  logic              Alloc_Valid,
   input  logic [NTAGS-1:0]  Alloc_Tag,
   input  logic              Br_Valid,
   input  logic              Br_Mispred,
   input  logic              Br_IsSpec,
   input  logic [NTAGS-1:0]  Br_Spectag,
   input  logic [63:0]       Br_Target,
   input  logic              Redirect_Ready,
   output logic              Kill_Enable,
   output logic [NTAGS-1:0]  Kill_VKillMask,
   output logic [NTAGS-1:0]  Tag_Free,
   output logic              Dispatch_Stall,
   output logic              Redirect_Valid,
   output logic [63:0]       Redirect_PC
);

   localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_KILL     = 2'd1,
      S_RESTORE  = 2'd2,
      S_REDIRECT = 2'd3
   } state_t;

   state_t                        state_q, state_d;
   logic [CNT_W-1:0]              cnt_q, cnt_d;
   logic [NTAGS-1:0]              live_q, live_d;
   logic [NTAGS-1:0][NTAGS-1:0]   older_q, older_d;
   logic [NTAGS-1:0]              m_q, m_d;
   logic [63:0]                   pc_q, pc_d;
   logic [NTAGS-1:0]              kill_set_q, kill_set_d;
   logic                          kill_en_q, kill_en_d;
   logic [NTAGS-1:0]              kill_mask_q, kill_mask_d;
   logic [NTAGS-1:0]              tag_free_q, tag_free_d;
   logic                          rv_q, rv_d;
   logic [63:0]                   rpc_q, rpc_d;

   logic                          run_s;
   logic                          resp_s;
   logic                          hit_live_s;
   logic [NTAGS-1:0]              m_row_s;
   logic                          older_than_m_s;
   logic                          accept_s;
   logic [NTAGS-1:0]              new_kill_s;
   logic [NTAGS-1:0]              kill_set_s;
   logic [NTAGS-1:0]              correct_free_s;
   logic [NTAGS-1:0]              free_s;
   logic [NTAGS-1:0]              alloc_mask_s;

   // Response qualification, kill-set and free-mask computation
   always_comb begin
      run_s          = rst & ~Flush;
      resp_s         = run_s & Br_Valid & Br_IsSpec;
      hit_live_s     = |(Br_Spectag & live_q);
      m_row_s        = '0;
      new_kill_s     = '0;
      for (int i = 0; i < NTAGS; i++) begin
         m_row_s       = m_row_s | (older_q[i] & {NTAGS{m_q[i]}});
         new_kill_s[i] = Br_Spectag[i] | (live_q[i] & (|(older_q[i] & Br_Spectag)));
      end
      older_than_m_s = |(m_row_s & Br_Spectag);
      // Outside IDLE only a strictly older branch may preempt; stale/killed tags are not live
      accept_s       = resp_s & Br_Mispred & hit_live_s &
                       ((state_q == S_IDLE) | older_than_m_s);
      kill_set_s     = new_kill_s | ((state_q != S_IDLE) ? kill_set_q : '0);
      correct_free_s = (resp_s & ~Br_Mispred) ? (Br_Spectag & live_q) : '0;
      // Only tags still live are returned, so a preempting kill never double-frees
      free_s         = correct_free_s | (accept_s ? (new_kill_s & live_q) : '0);
      alloc_mask_s   = (run_s & Alloc_Valid & (state_q == S_IDLE) & ~accept_s) ? Alloc_Tag : '0;
   end

   // Next-state, tag tracking and registered output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      live_d      = live_q;
      older_d     = older_q;
      m_d         = m_q;
      pc_d        = pc_q;
      kill_set_d  = kill_set_q;
      kill_en_d   = 1'b0;
      kill_mask_d = '0;
      tag_free_d  = '0;
      rv_d        = rv_q;
      rpc_d       = rpc_q;
      if (!run_s) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         live_d     = '0;
         older_d    = '0;
         m_d        = '0;
         pc_d       = '0;
         kill_set_d = '0;
         rv_d       = 1'b0;
         rpc_d      = '0;
      end else begin
         live_d     = (live_q & ~free_s) | alloc_mask_s;
         for (int i = 0; i < NTAGS; i++) begin
            older_d[i] = alloc_mask_s[i] ? (live_q & ~free_s & ~Alloc_Tag)
                                         : (older_q[i] & ~free_s);
         end
         tag_free_d = free_s;
         if (accept_s) begin
            state_d     = S_KILL;
            m_d         = Br_Spectag;
            pc_d        = Br_Target;
            kill_set_d  = kill_set_s;
            kill_en_d   = 1'b1;
            kill_mask_d = kill_set_s;
            rv_d        = 1'b0;
            rpc_d       = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  state_d = S_IDLE;
               end
               S_KILL: begin
                  state_d = S_RESTORE;
                  cnt_d   = CNT_W'(RESTORE_CYCLES - 1);
               end
               S_RESTORE: begin
                  if (cnt_q == '0) begin
                     state_d = S_REDIRECT;
                     rv_d    = 1'b1;
                     rpc_d   = pc_q & ~64'd1;
                  end else begin
                     cnt_d   = cnt_q - CNT_W'(1);
                  end
               end
               S_REDIRECT: begin
                  if (Redirect_Ready) begin
                     state_d = S_IDLE;
                     rv_d    = 1'b0;
                     rpc_d   = '0;
                  end else begin
                     state_d = S_REDIRECT;
                  end
               end
               default: begin
                  state_d = S_IDLE;
                  rv_d    = 1'b0;
                  rpc_d   = '0;
               end
            endcase
         end
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         live_q      <= '0;
         older_q     <= '0;
         m_q         <= '0;
         pc_q        <= '0;
         kill_set_q  <= '0;
         kill_en_q   <= 1'b0;
         kill_mask_q <= '0;
         tag_free_q  <= '0;
         rv_q        <= 1'b0;
         rpc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         live_q      <= live_d;
         older_q     <= older_d;
         m_q         <= m_d;
         pc_q        <= pc_d;
         kill_set_q  <= kill_set_d;
         kill_en_q   <= kill_en_d;
         kill_mask_q <= kill_mask_d;
         tag_free_q  <= tag_free_d;
         rv_q        <= rv_d;
         rpc_q       <= rpc_d;
      end
   end

   assign Kill_Enable    = kill_en_q;
   assign Kill_VKillMask = kill_mask_q;
   assign Tag_Free       = tag_free_q;
   assign Redirect_Valid = rv_q;
   assign Redirect_PC    = rpc_q;
   // The accept-cycle term lets dispatch stop before the kill lands
   assign Dispatch_Stall = (state_q != S_IDLE) | accept_s;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed table-driven bench for branch_recovery_ctrl with a few hand-written
// sequences for reset, the accept-cycle stall and redirect latency.
module tb_branch_recovery_ctrl;

   logic        clk;
   logic        rst;
   logic        Flush;
   logic        Alloc_Valid;
   logic [3:0]  Alloc_Tag;
   logic        Br_Valid;
   logic        Br_Mispred;
   logic        Br_IsSpec;
   logic [3:0]  Br_Spectag;
   logic [63:0] Br_Target;
   logic        Redirect_Ready;
   logic        Kill_Enable;
   logic [3:0]  Kill_VKillMask;
   logic [3:0]  Tag_Free;
   logic        Dispatch_Stall;
   logic        Redirect_Valid;
   logic [63:0] Redirect_PC;

   int checks   = 0;
   int failures = 0;

   branch_recovery_ctrl #(.NTAGS(4), .RESTORE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .Flush(Flush),
      .Alloc_Valid(Alloc_Valid), .Alloc_Tag(Alloc_Tag),
      .Br_Valid(Br_Valid), .Br_Mispred(Br_Mispred), .Br_IsSpec(Br_IsSpec),
      .Br_Spectag(Br_Spectag), .Br_Target(Br_Target),
      .Redirect_Ready(Redirect_Ready),
      .Kill_Enable(Kill_Enable), .Kill_VKillMask(Kill_VKillMask),
      .Tag_Free(Tag_Free), .Dispatch_Stall(Dispatch_Stall),
      .Redirect_Valid(Redirect_Valid), .Redirect_PC(Redirect_PC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic        av;
      logic [3:0]  at;
      logic        bv;
      logic        bm;
      logic        bs;
      logic [3:0]  bt;
      logic [63:0] tgt;
      logic        rdy;
      logic        ek;
      logic [3:0]  em;
      logic [3:0]  ef;
      logic        es;
      logic        erv;
      logic [63:0] epc;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic fl, input logic av, input logic [3:0] at,
                               input logic bv, input logic bm, input logic bs,
                               input logic [3:0] bt, input logic [63:0] tgt, input logic rdy,
                               input logic ek, input logic [3:0] em, input logic [3:0] ef,
                               input logic es, input logic erv, input logic [63:0] epc);
      vec_t v;
      v.flush = fl; v.av = av; v.at = at; v.bv = bv; v.bm = bm; v.bs = bs; v.bt = bt;
      v.tgt = tgt; v.rdy = rdy; v.ek = ek; v.em = em; v.ef = ef; v.es = es;
      v.erv = erv; v.epc = epc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      Flush = 1'b0; Alloc_Valid = 1'b0; Alloc_Tag = 4'b0000;
      Br_Valid = 1'b0; Br_Mispred = 1'b0; Br_IsSpec = 1'b0;
      Br_Spectag = 4'b0000; Br_Target = 64'd0; Redirect_Ready = 1'b0;
   endtask

   task automatic drive(input vec_t v);
      Flush = v.flush; Alloc_Valid = v.av; Alloc_Tag = v.at;
      Br_Valid = v.bv; Br_Mispred = v.bm; Br_IsSpec = v.bs;
      Br_Spectag = v.bt; Br_Target = v.tgt; Redirect_Ready = v.rdy;
   endtask

   // consume current inputs at the edge, then return inputs to idle before sampling
   task automatic step();
      @(posedge clk);
      #1;
      idle_in();
      #1;
   endtask

   task automatic chk_all(input string tag, input logic ek, input logic [3:0] em,
                          input logic [3:0] ef, input logic es, input logic erv,
                          input logic [63:0] epc);
      chk({tag, ".kill"},  {63'd0, Kill_Enable},    {63'd0, ek});
      chk({tag, ".mask"},  {60'd0, Kill_VKillMask}, {60'd0, em});
      chk({tag, ".free"},  {60'd0, Tag_Free},       {60'd0, ef});
      chk({tag, ".stall"}, {63'd0, Dispatch_Stall}, {63'd0, es});
      chk({tag, ".rv"},    {63'd0, Redirect_Valid}, {63'd0, erv});
      chk({tag, ".pc"},    Redirect_PC,             epc);
   endtask

   initial begin
      int n;
      // Scenario 1: allocate and correctly resolve a tag
      tv.push_back(mk(0,1,4'b0001, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,0,1,4'b0001, 64'd0, 0,  0,4'b0000,4'b0001,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      // Scenarios 2/3: mispredict middle tag, redirect held off by Ready=0
      tv.push_back(mk(0,1,4'b0001, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0010, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0100, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0010, 64'h8000_0041, 0,  1,4'b0110,4'b0110,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,1,64'h8000_0040));
      for (int k = 0; k < 5; k++)
         tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,1,64'h8000_0040));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 1,  0,4'b0000,4'b0000,0,0,64'd0));
      // stale mispred on an already-killed tag
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0100, 64'h1234, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      // Scenario 6: JAL mispredict ignored, correct resolve frees its tag
      tv.push_back(mk(0,0,4'b0000, 1,1,0,4'b0001, 64'h4444, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,0,1,4'b0001, 64'd0, 0,  0,4'b0000,4'b0001,0,0,64'd0));
      // Scenario 4: younger mispred, then older mispred preempts in RESTORE
      tv.push_back(mk(0,1,4'b0001, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0010, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0100, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0100, 64'h1000, 0,  1,4'b0100,4'b0100,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0001, 64'h2003, 0,  1,4'b0111,4'b0011,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,1,64'h2002));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 1,  0,4'b0000,4'b0000,0,0,64'd0));
      // Scenario 5: flush during REDIRECT, later mispred on old tag ignored
      tv.push_back(mk(0,1,4'b0001, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0010, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0100, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0100, 64'h3000, 0,  1,4'b0100,4'b0100,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,1,1,64'h3000));
      tv.push_back(mk(1,0,4'b0000, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,0,4'b0000, 1,1,1,4'b0001, 64'h5000, 0,  0,4'b0000,4'b0000,0,0,64'd0));
      tv.push_back(mk(0,1,4'b0001, 0,0,0,4'b0000, 64'd0, 0,  0,4'b0000,4'b0000,0,0,64'd0));

      // Reset held two cycles with activity on the inputs
      idle_in();
      rst = 1'b0;
      Alloc_Valid = 1'b1; Alloc_Tag = 4'b0001;
      Br_Valid = 1'b1; Br_Mispred = 1'b1; Br_IsSpec = 1'b1; Br_Spectag = 4'b0001;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 64'd0);
      idle_in();
      rst = 1'b1;
      #1;

      for (int i = 0; i < tv.size(); i++) begin
         drive(tv[i]);
         step();
         chk_all($sformatf("row%0d", i), tv[i].ek, tv[i].em, tv[i].ef, tv[i].es,
                 tv[i].erv, tv[i].epc);
      end

      // Hand sequence: stall in the accept cycle, then bounded redirect latency
      Alloc_Valid = 1'b1; Alloc_Tag = 4'b0010;
      step();
      Br_Valid = 1'b1; Br_Mispred = 1'b1; Br_IsSpec = 1'b1;
      Br_Spectag = 4'b0010; Br_Target = 64'h0000_0000_0000_0077;
      #1;
      chk("accept_stall", {63'd0, Dispatch_Stall}, 64'd1);
      step();
      chk("lat_kill_mask", {60'd0, Kill_VKillMask}, 64'h2);
      n = 1;
      while (!Redirect_Valid && n < 20) begin
         step();
         n++;
      end
      chk("redirect_latency", n, 64'd4);
      chk("redirect_pc", Redirect_PC, 64'h76);
      Redirect_Ready = 1'b1;
      step();
      chk("after_handshake_rv", {63'd0, Redirect_Valid}, 64'd0);
      chk("after_handshake_stall", {63'd0, Dispatch_Stall}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
